if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and drives the instruction-memory request/ready handshake. It supplies the IF/ID register with instruction, PC+4, write enable, flush and hold. It applies stall from hazard detection and branch/jump redirects from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, sequential PC increment in bytes

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_pc_write  input  1  1 = PC may advance; 0 = stall from hazard unit
i_branch_taken  input  1  taken branch resolved downstream (highest priority)
i_branch_target  input  32  branch target address
i_jump  input  1  jump decoded in ID
i_jump_target  input  32  jump target address
o_imem_addr  output  32  instruction-memory address (= PC)
o_imem_req  output  1  fetch request valid
i_imem_ready  input  1  memory data valid this cycle
i_imem_data  input  32  instruction word
o_inst  output  32  instruction to IF/ID i_data
o_next_pc  output  32  PC+PC_INC to IF/ID i_next_pc
o_ifid_write  output  1  IF/ID write enable
o_if_flush  output  1  IF/ID flush
o_hold  output  1  IF/ID hold (fetch waiting on memory)

Behaviour:
- One clock (i_clk); reset asynchronous, active-low (i_rst_n).
- States: S_BOOT, S_FETCH, S_DISCARD.
- Reset values: pc=RESET_PC, state=S_BOOT, o_imem_req=0, o_ifid_write=0, o_if_flush=0, o_hold=0, o_inst=0, o_next_pc=0.
- S_BOOT: all outputs idle. First rising edge after reset release moves to S_FETCH. The first request appears 1 cycle after release.
- S_FETCH: o_imem_req=1; o_imem_addr=pc; o_next_pc=pc+PC_INC, wrapping mod 2^32.
- Accept (i_imem_ready=1, i_pc_write=1, no redirect):
  - o_inst=i_imem_data, combinational.
  - o_ifid_write=1.
  - pc<=pc+PC_INC.
  - Zero added latency: data returned in cycle N is written into IF/ID at the edge ending cycle N.
- Memory wait (i_imem_ready=0): o_hold=1, o_ifid_write=0, o_inst=0; pc holds; address stays stable.
- Stall (i_pc_write=0, no redirect):
  - pc holds; o_ifid_write=0; o_inst=0.
  - Request stays asserted on the same address, and returned data is dropped.
  - The same address is refetched once the stall clears.
- Redirect priority: i_branch_taken > i_jump > stall > sequential. A redirect overrides a stall.
- Redirect with i_imem_ready=1:
  - pc<=target with bits[1:0] forced to 00.
  - o_if_flush=1 for exactly that cycle; o_ifid_write=0; state stays S_FETCH.
- Redirect with i_imem_ready=0:
  - o_if_flush=1 that cycle; the target is latched into pc; state<=S_DISCARD.
- S_DISCARD:
  - o_imem_req=0; o_hold=1; o_ifid_write=0.
  - The stale response (first i_imem_ready=1) is dropped, and the next state is S_FETCH at the new pc.
  - A further redirect in S_DISCARD overwrites pc, raises o_if_flush for that cycle, and stays in S_DISCARD.
- o_ifid_write and o_if_flush are never both 1.
- Reset asserted mid-operation: immediate return to reset values regardless of state; any outstanding memory response is ignored.

Optional Feature:
Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - o_fetch_cnt (32): number of o_ifid_write=1 cycles.
  - o_bubble_cnt (32): number of S_FETCH/S_DISCARD cycles with o_ifid_write=0.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and never wrap.
- When undefined, the ports and counters are absent and core behaviour is identical.

Test Plan:
- Reset release, i_imem_ready=1 always, data 0x11111111/0x22222222 -> req in cycle 1; addr 0x0, 0x4, 0x8; o_ifid_write=1 each cycle; o_next_pc 0x4, 0x8, 0xC.
- At pc=0x8, i_imem_ready=0 for 3 cycles -> o_hold=1 and addr=0x8 held for 3 cycles; o_ifid_write=0; then data written, pc->0xC.
- At pc=0x10, i_imem_ready=1, i_branch_taken=1, target 0x40 -> o_if_flush=1 one cycle, o_ifid_write=0, next addr 0x40.
- i_branch_taken (0x80) and i_jump (0x200) and i_pc_write=0 together -> pc=0x80, flush=1.
- Redirect to 0x102 while ready=0 -> S_DISCARD, req=0; stale data dropped; next fetch at addr 0x100.
- pc=0xFFFF_FFFC accepted -> o_next_pc=0x0, next addr 0x0. Assert i_rst_n=0 mid-wait -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ready handshake and feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters (o_fetch_cnt, o_bubble_cnt).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_write,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_inst,
    output logic [31:0] o_next_pc,
    output logic        o_ifid_write,
    output logic        o_if_flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt,
`endif
    output logic        o_hold
);

    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus;
    logic [31:0] redirect_target;
    logic        redirect;

    assign pc_plus         = pc + 32'(PC_INC);
    assign redirect        = i_branch_taken | i_jump;
    assign redirect_target = (i_branch_taken ? i_branch_target : i_jump_target) & 32'hFFFF_FFFC;
    assign o_imem_addr     = pc;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        o_imem_req   = 1'b0;
        o_inst       = '0;
        o_next_pc    = '0;
        o_ifid_write = 1'b0;
        o_if_flush   = 1'b0;
        o_hold       = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_next_pc  = pc_plus;
                o_hold     = ~i_imem_ready;
                if (redirect) begin
                    // An in-flight request with no response yet must have its reply skipped.
                    o_if_flush = 1'b1;
                    pc_next    = redirect_target;
                    if (!i_imem_ready) begin
                        state_next = S_DISCARD;
                    end
                end else if (i_imem_ready && i_pc_write) begin
                    o_inst       = i_imem_data;
                    o_ifid_write = 1'b1;
                    pc_next      = pc_plus;
                end
            end
            S_DISCARD: begin
                o_hold = 1'b1;
                if (redirect) begin
                    o_if_flush = 1'b1;
                    pc_next    = redirect_target;
                end else if (i_imem_ready) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic bubble;

    assign bubble = ((state == S_FETCH) || (state == S_DISCARD)) && !o_ifid_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (o_ifid_write && (o_fetch_cnt != '1)) begin
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            if (bubble && (o_bubble_cnt != '1)) begin
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios then random traffic against a reference model.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] next_pc;
        logic        req;
        logic        wr;
        logic        flush;
        logic        hold;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] inst;
    logic [31:0] next_pc;
    logic        ifid_write;
    logic        if_flush;
    logic        hold;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    obs_t        exp_q[$];

    // Reference model: where the fetcher is, and whether it is still waiting to skip a stale reply.
    int unsigned m_phase = 0;   // 0 = just out of reset, 1 = fetching, 2 = skipping stale reply
    logic [31:0] m_pc = 32'h0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pc_write     (pc_write),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .i_jump         (jump),
        .i_jump_target  (jump_target),
        .o_imem_addr    (imem_addr),
        .o_imem_req     (imem_req),
        .i_imem_ready   (imem_ready),
        .i_imem_data    (imem_data),
        .o_inst         (inst),
        .o_next_pc      (next_pc),
        .o_ifid_write   (ifid_write),
        .o_if_flush     (if_flush),
        .o_hold         (hold)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic pcw, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic rdy, input logic [31:0] data);
        obs_t        e;
        logic [31:0] tgt;
        logic        redir;
        @(negedge clk);
        rst_n = rst; pc_write = pcw; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; imem_ready = rdy; imem_data = data;
        e     = '0;
        redir = br || jp;
        tgt   = br ? bt : jt;
        tgt   = tgt - (tgt % 4);
        if (!rst) begin
            m_phase = 0;
            m_pc    = 32'h0;
        end else if (m_phase == 0) begin
            e.addr  = m_pc;
            m_phase = 1;
        end else if (m_phase == 1) begin
            e.addr    = m_pc;
            e.req     = 1'b1;
            e.next_pc = m_pc + 32'd4;
            e.hold    = !rdy;
            if (redir) begin
                e.flush = 1'b1;
                m_pc    = tgt;
                if (!rdy) m_phase = 2;
            end else if (rdy && pcw) begin
                e.wr   = 1'b1;
                e.inst = data;
                m_pc   = m_pc + 32'd4;
            end
        end else begin
            e.addr = m_pc;
            e.hold = 1'b1;
            if (redir) begin
                e.flush = 1'b1;
                m_pc    = tgt;
            end else if (rdy) begin
                m_phase = 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic seq(input logic rdy, input logic [31:0] data);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, rdy, data);
    endtask

    // Monitor: every cycle the DUT presents an output vector, compare it with the oldest expectation.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{addr: imem_addr, inst: inst, next_pc: next_pc, req: imem_req,
                      wr: ifid_write, flush: if_flush, hold: hold};
                compared++;
                if (a !== e || (ifid_write && if_flush)) begin
                    mismatched++;
                    $display("FAIL outputs @%0t: got addr=%h inst=%h next_pc=%h req=%b wr=%b flush=%b hold=%b ; want addr=%h inst=%h next_pc=%h req=%b wr=%b flush=%b hold=%b",
                             $time, a.addr, a.inst, a.next_pc, a.req, a.wr, a.flush, a.hold,
                             e.addr, e.inst, e.next_pc, e.req, e.wr, e.flush, e.hold);
                end
            end
        end
    end

    initial begin
        logic rst;
        // Reset, release, sequential fetches at 0x0/0x4/0x8
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        seq(1'b1, 32'h1111_1111);
        seq(1'b1, 32'h1111_1111);
        seq(1'b1, 32'h2222_2222);
        // Memory wait at 0x8 for three cycles, then accept
        seq(1'b0, 32'h3333_3333);
        seq(1'b0, 32'h3333_3333);
        seq(1'b0, 32'h3333_3333);
        seq(1'b1, 32'h4444_4444);
        seq(1'b1, 32'h5555_5555);
        // Taken branch at 0x10 with data ready
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
        seq(1'b1, 32'h7777_7777);
        // Branch beats jump beats stall
        step(1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200, 1'b1, 32'h8888_8888);
        seq(1'b1, 32'h9999_9999);
        // Redirect while waiting: misaligned target, stale reply skipped
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
        seq(1'b0, 32'hAAAA_AAAA);
        seq(1'b1, 32'hBBBB_BBBB);
        seq(1'b1, 32'hCCCC_CCCC);
        // Redirect again from inside the skip window
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b1, 32'h1234_5678);
        seq(1'b1, 32'h0F0F_0F0F);
        seq(1'b1, 32'h1357_9BDF);
        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        seq(1'b1, 32'hFEED_F00D);
        seq(1'b1, 32'hCAFE_BABE);
        // Stall with data ready: dropped and refetched
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5A5A_5A5A);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5A5A_5A5A);
        seq(1'b1, 32'hA5A5_A5A5);
        // Asynchronous reset in the middle of a memory wait
        seq(1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
        seq(1'b1, 32'h0101_0101);
        seq(1'b1, 32'h0202_0202);
        // Random traffic
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = (rst == 1'b0) ? 1'b1 : ($urandom_range(0, 299) != 0);
            step(rst, $urandom_range(0, 99) < 85, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 99) < 75, $urandom);
        end
        @(negedge clk);
        #5;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
